// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants, timing bundle type and sizing helpers
// for the timing generator and its delay line.
package vga_timing_pkg;

    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FP     = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BP     = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FP     = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BP     = 33;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic lineStart;
        logic frameStart;
    } timing_t;

    function automatic int unsigned hTotal(input int unsigned active, frontPorch, syncWidth, backPorch);
        return active + frontPorch + syncWidth + backPorch;
    endfunction

    function automatic int unsigned vTotal(input int unsigned active, frontPorch, syncWidth, backPorch);
        return active + frontPorch + syncWidth + backPorch;
    endfunction

    function automatic int unsigned cntWidth(input int unsigned total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift pipeline of DEPTH stages; DEPTH=0 is a plain wire.
// Reset loads every stage with RST_VAL.
module vga_delay_line #(
    parameter int unsigned        WIDTH   = 1,
    parameter int unsigned        DEPTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : gPass
        logic unusedSink;
        assign unusedSink = ^{clk, rst, en, RST_VAL};
        assign dout = din;
    end else if (DEPTH == 1) begin : gOne
        logic [WIDTH-1:0] stage;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)     stage <= RST_VAL;
            else if (en) stage <= din;
        end
        assign dout = stage;
    end else begin : gMany
        // Stage 0 sits in the low slice; the oldest entry is the top slice.
        logic [DEPTH*WIDTH-1:0] stages;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)     stages <= {DEPTH{RST_VAL}};
            else if (en) stages <= {stages[(DEPTH-1)*WIDTH-1:0], din};
        end
        assign dout = stages[DEPTH*WIDTH-1 -: WIDTH];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: request counters issue coordinates
// LOOKAHEAD pixel ticks ahead of the delayed sync/de/strobe outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA640_H_ACTIVE,
    parameter int unsigned H_FP      = VGA640_H_FP,
    parameter int unsigned H_SYNC    = VGA640_H_SYNC,
    parameter int unsigned H_BP      = VGA640_H_BP,
    parameter int unsigned V_ACTIVE  = VGA640_V_ACTIVE,
    parameter int unsigned V_FP      = VGA640_V_FP,
    parameter int unsigned V_SYNC    = VGA640_V_SYNC,
    parameter int unsigned V_BP      = VGA640_V_BP,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0,
    parameter int unsigned PIX_W     = 12,
    parameter int unsigned LOOKAHEAD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [PIX_W-1:0] pixel_in,
    output logic [PIX_W-1:0] pixel_out,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [cntWidth(hTotal(H_ACTIVE, H_FP, H_SYNC, H_BP))-1:0] pos_x,
    output logic [cntWidth(vTotal(V_ACTIVE, V_FP, V_SYNC, V_BP))-1:0] pos_y,
    output logic             pos_valid,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = hTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = cntWidth(H_TOTAL);
    localparam int unsigned VW      = cntWidth(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam timing_t IDLE_T = '{hsync: ~HS_POL, vsync: ~VS_POL, de: 1'b0,
                                   lineStart: 1'b0, frameStart: 1'b0};

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0 || LOOKAHEAD > 8) begin : gBadParams
        $error("vga_timing_gen: porch/sync widths must be nonzero and LOOKAHEAD <= 8");
    end

    logic [HW-1:0] hCnt;
    logic [VW-1:0] vCnt;
    timing_t       rawT;
    timing_t       dlyT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (pix_en) begin
            if (hCnt == H_LAST) begin
                hCnt <= '0;
                vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
            end else begin
                hCnt <= hCnt + 1'b1;
            end
        end
    end

    always_comb begin
        rawT            = IDLE_T;
        rawT.hsync      = (hCnt >= H_SYNC_START && hCnt < H_SYNC_END) ? HS_POL : ~HS_POL;
        rawT.vsync      = (vCnt >= V_SYNC_START && vCnt < V_SYNC_END) ? VS_POL : ~VS_POL;
        rawT.de         = (hCnt < H_ACT) && (vCnt < V_ACT);
        rawT.lineStart  = (hCnt == '0) && (vCnt < V_ACT);
        rawT.frameStart = (hCnt == '0) && (vCnt == '0);
    end

    vga_delay_line #(
        .WIDTH   ($bits(timing_t)),
        .DEPTH   (LOOKAHEAD),
        .RST_VAL (IDLE_T)
    ) uDelay (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .din  (rawT),
        .dout (dlyT)
    );

    assign pos_x     = hCnt;
    assign pos_y     = vCnt;
    assign pos_valid = (hCnt < H_ACT) && (vCnt < V_ACT);

    assign hsync     = dlyT.hsync;
    assign vsync     = dlyT.vsync;
    assign de        = dlyT.de;
    assign pixel_out = dlyT.de ? pixel_in : '0;

    // The output stage holds across stalled ticks; gating with pix_en
    // keeps each strobe to the single clk on which that stage advances.
    assign line_start  = dlyT.lineStart  & pix_en;
    assign frame_start = dlyT.frameStart & pix_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: four parameterisations checked every cycle against
// an arithmetic raster model, plus hand-computed literal expectations.
module tb_vga_timing_gen;

    typedef struct packed {
        logic hs; logic vs; logic de; logic ls; logic fs; logic pv;
        int px; int x; int y;
    } expT;

    logic clk;
    logic rst;
    logic peFull;
    logic pe4;
    logic modelOn;
    int   checks;
    int   failures;
    int   n0, n1, n2, n3;
    int   cyc4;

    // d0: 640x480 defaults, LOOKAHEAD 2
    logic [11:0] pixIn0, pixOut0;
    logic        hs0, vs0, de0, ls0, fs0, pv0;
    logic [9:0]  px0, py0;
    logic [9:0]  pd0 [2];
    // d1: 8x4 tiny raster, LOOKAHEAD 2
    logic [7:0]  pixIn1, pixOut1;
    logic        hs1, vs1, de1, ls1, fs1, pv1;
    logic [3:0]  px1;
    logic [2:0]  py1;
    logic [3:0]  pd1 [2];
    // d2: tiny raster, positive syncs, LOOKAHEAD 3, pix_en 1-in-4
    logic [7:0]  pixIn2, pixOut2;
    logic        hs2, vs2, de2, ls2, fs2, pv2;
    logic [3:0]  px2;
    logic [2:0]  py2;
    logic [3:0]  pd2 [3];
    // d3: 800x600, LOOKAHEAD 0
    logic [11:0] pixIn3, pixOut3;
    logic        hs3, vs3, de3, ls3, fs3, pv3;
    logic [10:0] px3;
    logic [9:0]  py3;

    assign pixIn0 = {2'b00, pd0[1]};
    assign pixIn1 = {4'h0, pd1[1]};
    assign pixIn2 = {4'h0, pd2[2]};
    assign pixIn3 = {1'b0, px3};

    vga_timing_gen u0 (
        .clk(clk), .rst(rst), .pix_en(peFull), .pixel_in(pixIn0), .pixel_out(pixOut0),
        .hsync(hs0), .vsync(vs0), .de(de0), .pos_x(px0), .pos_y(py0), .pos_valid(pv0),
        .line_start(ls0), .frame_start(fs0));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_W(8), .LOOKAHEAD(2)
    ) u1 (
        .clk(clk), .rst(rst), .pix_en(peFull), .pixel_in(pixIn1), .pixel_out(pixOut1),
        .hsync(hs1), .vsync(vs1), .de(de1), .pos_x(px1), .pos_y(py1), .pos_valid(pv1),
        .line_start(ls1), .frame_start(fs1));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_W(8), .LOOKAHEAD(3)
    ) u2 (
        .clk(clk), .rst(rst), .pix_en(pe4), .pixel_in(pixIn2), .pixel_out(pixOut2),
        .hsync(hs2), .vsync(vs2), .de(de2), .pos_x(px2), .pos_y(py2), .pos_valid(pv2),
        .line_start(ls2), .frame_start(fs2));

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .LOOKAHEAD(0)
    ) u3 (
        .clk(clk), .rst(rst), .pix_en(peFull), .pixel_in(pixIn3), .pixel_out(pixOut3),
        .hsync(hs3), .vsync(vs3), .de(de3), .pos_x(px3), .pos_y(py3), .pos_valid(pv3),
        .line_start(ls3), .frame_start(fs3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        pe4  = 1'b0;
        cyc4 = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc4 = cyc4 + 1;
            pe4  = (cyc4 % 4 == 0);
        end
    end

    // Tick counts since reset release and the emulated fixed-latency pixel source.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n0 <= 0; n1 <= 0; n2 <= 0; n3 <= 0;
        end else begin
            if (peFull) begin
                n0 <= n0 + 1; n1 <= n1 + 1; n3 <= n3 + 1;
                pd0[0] <= px0; pd0[1] <= pd0[0];
                pd1[0] <= px1; pd1[1] <= pd1[0];
            end
            if (pe4) begin
                n2 <= n2 + 1;
                pd2[0] <= px2; pd2[1] <= pd2[0]; pd2[2] <= pd2[1];
            end
        end
    end

    // Output index c = ticks - lookahead; before the pipeline fills, outputs are idle.
    function automatic expT model(input int ha, hf, hsw, hb, va, vf, vsw, vb,
                                  input logic hp, vp, input int la, n, input logic en);
        expT e;
        int ht, vt, c, h, v;
        ht   = ha + hf + hsw + hb;
        vt   = va + vf + vsw + vb;
        e.x  = n % ht;
        e.y  = (n / ht) % vt;
        e.pv = (e.x < ha) && (e.y < va);
        c    = n - la;
        if (c < 0) begin
            e.hs = ~hp; e.vs = ~vp; e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.px = 0;
        end else begin
            h    = c % ht;
            v    = (c / ht) % vt;
            e.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
            e.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
            e.de = (h < ha) && (v < va);
            e.px = e.de ? h : 0;
            e.ls = en && (h == 0) && (v < va);
            e.fs = en && (h == 0) && (v == 0);
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input expT e, input logic hs, vs, de, ls, fs, pv,
                       input int px, x, y);
        chk({tag, ".hsync"},       int'(hs), int'(e.hs));
        chk({tag, ".vsync"},       int'(vs), int'(e.vs));
        chk({tag, ".de"},          int'(de), int'(e.de));
        chk({tag, ".line_start"},  int'(ls), int'(e.ls));
        chk({tag, ".frame_start"}, int'(fs), int'(e.fs));
        chk({tag, ".pos_valid"},   int'(pv), int'(e.pv));
        chk({tag, ".pixel_out"},   px, e.px);
        chk({tag, ".pos_x"},       x, e.x);
        chk({tag, ".pos_y"},       y, e.y);
    endtask

    always @(negedge clk) begin
        if (modelOn && !rst) begin
            cmp("d0", model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, n0, peFull),
                hs0, vs0, de0, ls0, fs0, pv0, int'(pixOut0), int'(px0), int'(py0));
            cmp("d1", model(8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 2, n1, peFull),
                hs1, vs1, de1, ls1, fs1, pv1, int'(pixOut1), int'(px1), int'(py1));
            cmp("d2", model(8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1, 3, n2, pe4),
                hs2, vs2, de2, ls2, fs2, pv2, int'(pixOut2), int'(px2), int'(py2));
            cmp("d3", model(800, 40, 128, 88, 600, 1, 4, 23, 1'b0, 1'b0, 0, n3, peFull),
                hs3, vs3, de3, ls3, fs3, pv3, int'(pixOut3), int'(px3), int'(py3));
        end
    end

    initial begin
        int hsLow0, deCnt0, fsCnt1, vsLow1, deCnt1, fsCnt2;
        int rise2a, rise2b, prevHs2;
        int x3a, x3b, y3b, fsAfter [4];
        bit found;

        checks = 0; failures = 0; modelOn = 1'b0;
        rst = 1'b1; peFull = 1'b1;
        hsLow0 = 0; deCnt0 = 0; fsCnt1 = 0; vsLow1 = 0; deCnt1 = 0; fsCnt2 = 0;
        rise2a = -1; rise2b = -1; prevHs2 = 0; x3a = -1; x3b = -1; y3b = -1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.d0.hsync",     int'(hs0), 1);
        chk("rst.d0.vsync",     int'(vs0), 1);
        chk("rst.d0.de",        int'(de0), 0);
        chk("rst.d0.pixel_out", int'(pixOut0), 0);
        chk("rst.d0.fs",        int'(fs0), 0);
        chk("rst.d2.hsync",     int'(hs2), 0);
        chk("rst.d2.vsync",     int'(vs2), 0);

        @(negedge clk);
        #2 rst = 1'b0;
        modelOn = 1'b1;
        #1;
        chk("rel.d3.fs_lookahead0", int'(fs3), 1);
        chk("rel.d0.fs_not_yet",    int'(fs0), 0);

        prevHs2 = int'(hs2);
        for (int i = 0; i < 2400; i++) begin
            @(negedge clk);
            if (!hs0) hsLow0++;
            if (de0)  deCnt0++;
            if (fs1)  fsCnt1++;
            if (!vs1) vsLow1++;
            if (de1)  deCnt1++;
            if (fs2)  fsCnt2++;
            if (hs2 && prevHs2 == 0) begin
                if (rise2a < 0)      rise2a = i;
                else if (rise2b < 0) rise2b = i;
            end
            prevHs2 = int'(hs2);
            if (i == 1054) x3a = int'(px3);
            if (i == 1055) begin x3b = int'(px3); y3b = int'(py3); end
        end
        chk("win.d0.hsync_low_clks",  hsLow0, 288);
        chk("win.d0.de_clks",         deCnt0, 1920);
        chk("win.d1.frame_starts",    fsCnt1, 20);
        chk("win.d1.vsync_low_clks",  vsLow1, 600);
        chk("win.d1.de_clks",         deCnt1, 640);
        chk("win.d2.frame_starts",    fsCnt2, 5);
        chk("win.d2.hsync_period",    rise2b - rise2a, 60);
        chk("wrap.d3.pos_x_last",     x3a, 1055);
        chk("wrap.d3.pos_x_zero",     x3b, 0);
        chk("wrap.d3.pos_y_next",     y3b, 1);

        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (px0 == 10'd300) found = 1'b1;
        end
        chk("midrst.d0.reach_x300", int'(found), 1);

        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst.d0.hsync",     int'(hs0), 1);
        chk("midrst.d0.de",        int'(de0), 0);
        chk("midrst.d0.pixel_out", int'(pixOut0), 0);
        chk("midrst.d0.ls",        int'(ls0), 0);
        chk("midrst.d0.pos_x",     int'(px0), 0);
        chk("midrst.d0.pos_y",     int'(py0), 0);
        chk("midrst.d2.hsync",     int'(hs2), 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fsAfter[i] = int'(fs0);
        end
        chk("midrst.d0.fs_tick1", fsAfter[0], 0);
        chk("midrst.d0.fs_tick2", fsAfter[1], 1);
        chk("midrst.d0.fs_tick3", fsAfter[2], 0);

        repeat (500) @(negedge clk);
        modelOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
